// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: active-low one-hot column drive, two-flop row synchroniser,
// tick-paced press/release debounce, and {counter, keyboard} hand-off to the encoder.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [1:0] counter,
    output logic [3:0] keyboard,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    CNT_MAX = 8'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [3:0]    rows_meta, rows_sync, cap_row;
    logic [PW-1:0] prescaler;
    logic [7:0]    count;
    logic [1:0]    scan_index, cap_col;
    logic [2:0]    zeros;
    logic          tick, idle, single;

    always_comb begin
        zeros  = 3'(!rows_sync[0]) + 3'(!rows_sync[1]) + 3'(!rows_sync[2]) + 3'(!rows_sync[3]);
        idle   = (rows_sync == 4'hF);
        single = (zeros == 3'd1);
        tick   = (prescaler == PRE_MAX);
    end

    assign columns = ~(4'b0001 << scan_index);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            prescaler <= '0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCAN;
            scan_index <= 2'd0;
            count      <= 8'd0;
            cap_row    <= 4'hF;
            cap_col    <= 2'd0;
            counter    <= 2'd0;
            keyboard   <= 4'hF;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            multi_key  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (idle) begin
                            scan_index <= scan_index + 2'd1;
                        end else if (single) begin
                            cap_row <= rows_sync;
                            cap_col <= scan_index;
                            count   <= 8'd1;
                            if (CNT_MAX == 8'd1) begin
                                keyboard  <= rows_sync;
                                counter   <= scan_index;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            multi_key  <= 1'b1;
                            scan_index <= scan_index + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (rows_sync == cap_row) begin
                            count <= count + 8'd1;
                            if (count + 8'd1 == CNT_MAX) begin
                                keyboard  <= cap_row;
                                counter   <= cap_col;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            state      <= SCAN;
                            scan_index <= scan_index + 2'd1;
                        end
                    end
                    // Column stays frozen; only an all-idle sample starts the release count.
                    HELD: begin
                        if (idle) begin
                            count <= 8'd1;
                            if (CNT_MAX == 8'd1) begin
                                key_held   <= 1'b0;
                                state      <= SCAN;
                                scan_index <= scan_index + 2'd1;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (idle) begin
                            count <= count + 8'd1;
                            if (count + 8'd1 == CNT_MAX) begin
                                key_held   <= 1'b0;
                                state      <= SCAN;
                                scan_index <= scan_index + 2'd1;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad modelled from the column drive, cycle-level
// behavioural reference compared every cycle, plus directed literal checks.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 3;
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] rows;
    logic [3:0] columns;
    logic [1:0] counter;
    logic [3:0] keyboard;
    logic       key_valid, key_held, multi_key;

    logic [3:0] press [4];   // press[c][r]=1: key at column c / row r is down

    int n_vec = 0;
    int n_err = 0;
    int kv_cnt = 0;
    int mk_cnt = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clock(clock), .reset_n(reset_n), .rows(rows), .columns(columns),
        .counter(counter), .keyboard(keyboard), .key_valid(key_valid),
        .key_held(key_held), .multi_key(multi_key)
    );

    always #5 clock = ~clock;

    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!columns[c]) rows = rows & ~press[c];
    end

    // ---------------- behavioural reference ----------------
    int         m_cyc, m_mode, m_col, m_n, m_cap_col, m_ctr;
    logic [3:0] m_s1, m_s2, m_cap_row, m_kb;
    bit         m_kv, m_mk;

    function automatic int zeros(logic [3:0] v);
        int z = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) z++;
        return z;
    endfunction

    task automatic m_reset();
        m_cyc = 0; m_mode = M_SCAN; m_col = 0; m_n = 0; m_cap_col = 0; m_ctr = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_cap_row = 4'hF; m_kb = 4'hF; m_kv = 0; m_mk = 0;
    endtask

    task automatic m_accept();
        m_kb = m_cap_row; m_ctr = m_cap_col; m_kv = 1; m_mode = M_HELD;
    endtask

    task automatic m_leave();
        m_mode = M_SCAN; m_col = (m_col + 1) % 4;
    endtask

    // Advance the reference across one rising edge using the inputs held this cycle.
    task automatic m_step();
        logic [3:0] s;
        bit tk;
        s  = m_s2;
        tk = (m_cyc % SD) == SD - 1;
        m_s2 = m_s1; m_s1 = rows; m_cyc++;
        m_kv = 0; m_mk = 0;
        if (!tk) return;
        case (m_mode)
            M_SCAN:
                if (s == 4'hF) m_col = (m_col + 1) % 4;
                else if (zeros(s) == 1) begin
                    m_cap_row = s; m_cap_col = m_col; m_n = 1;
                    if (m_n == DC) m_accept(); else m_mode = M_DEB;
                end else begin
                    m_mk = 1; m_col = (m_col + 1) % 4;
                end
            M_DEB:
                if (s == m_cap_row) begin
                    m_n++;
                    if (m_n == DC) m_accept();
                end else m_leave();
            M_HELD:
                if (s == 4'hF) begin
                    m_n = 1;
                    if (m_n == DC) m_leave(); else m_mode = M_REL;
                end
            default:
                if (s == 4'hF) begin
                    m_n++;
                    if (m_n == DC) m_leave();
                end else m_mode = M_HELD;
        endcase
    endtask

    always @(negedge clock) begin
        logic [3:0]  ec;
        logic [12:0] exp_v, act_v;
        if (!reset_n) m_reset();
        ec = 4'b0001 << m_col;
        ec = ~ec;
        exp_v = {ec, 2'(m_ctr), m_kb, m_kv, (m_mode == M_HELD || m_mode == M_REL), m_mk};
        act_v = {columns, counter, keyboard, key_valid, key_held, multi_key};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_model t=%0t got=%b want=%b (cols,ctr,kb,kv,held,mk)", $time, act_v, exp_v);
        end
        if (key_valid) kv_cnt++;
        if (multi_key) mk_cnt++;
        if (reset_n) m_step();
    end

    // ---------------- directed helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tmo(string name);
        n_vec++; n_err++;
        $display("FAIL %s timeout got=expired want=event", name);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_mode(int mode, int budget, string name);
        int i = 0;
        while (m_mode != mode && i < budget) begin cyc(1); i++; end
        if (m_mode != mode) tmo(name);
    endtask

    task automatic wait_kv(int budget, string name, output int lat);
        lat = 0;
        do begin cyc(1); lat++; end while (!key_valid && lat < budget);
        if (!key_valid) tmo(name);
    endtask

    task automatic wait_release(int budget, string name);
        int i = 0;
        while (key_held && i < budget) begin cyc(1); i++; end
        if (key_held) tmo(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int kv0, mk0, lat, dwell, nchg;
        logic [3:0] prev;
        logic [3:0] seq [4];
        int dw [4];
        for (int c = 0; c < 4; c++) press[c] = 4'h0;
        m_reset();
        cyc(2);
        chk("reset_outs", {columns, counter, keyboard, key_valid, key_held, multi_key},
            {4'b1110, 2'b00, 4'b1111, 3'b000});
        reset_n = 1'b1;

        // 1: idle scan order and dwell
        kv0 = kv_cnt; mk0 = mk_cnt;
        prev = columns; dwell = 0; nchg = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1); dwell++;
            if (columns !== prev && nchg < 4) begin
                seq[nchg] = columns; dw[nchg] = dwell; nchg++; dwell = 0;
            end
            prev = columns;
        end
        chk("s1_nchg", nchg, 4);
        chk("s1_col1", seq[0], 4'b1101);
        chk("s1_col2", seq[1], 4'b1011);
        chk("s1_col3", seq[2], 4'b0111);
        chk("s1_col0", seq[3], 4'b1110);
        chk("s1_dwell2", dw[1], 4);
        chk("s1_dwell3", dw[2], 4);
        chk("s1_dwell0", dw[3], 4);
        cyc(76);
        chk("s1_no_kv", kv_cnt - kv0, 0);
        chk("s1_no_mk", mk_cnt - mk0, 0);

        // 2: clean press at column 2 / row 1
        kv0 = kv_cnt;
        press[2] = 4'b0010;
        wait_mode(M_DEB, 100, "s2_detect");
        wait_kv(100, "s2_kv", lat);
        chk("s2_latency", lat, 8);
        cyc(200);
        chk("s2_one_kv", kv_cnt - kv0, 1);
        chk("s2_counter", counter, 2'b10);
        chk("s2_keyboard", keyboard, 4'b1101);
        chk("s2_held", key_held, 1);
        chk("s2_cols_frozen", columns, 4'b1011);

        // 3: release
        press[2] = 4'h0;
        wait_release(100, "s3_release");
        chk("s3_cols_resume", columns, 4'b0111);
        chk("s3_kb_kept", keyboard, 4'b1101);
        chk("s3_ctr_kept", counter, 2'b10);

        // 4: one-tick bounce, then a release-side glitch
        wait_mode(M_SCAN, 10, "s4_scan");
        kv0 = kv_cnt;
        press[2] = 4'b0010;
        wait_mode(M_DEB, 100, "s4_detect");
        press[2] = 4'h0;
        wait_mode(M_SCAN, 20, "s4_abort");
        chk("s4_next_col", columns, 4'b0111);
        cyc(40);
        chk("s4_no_kv", kv_cnt - kv0, 0);
        press[2] = 4'b0010;
        wait_mode(M_HELD, 100, "s4_held");
        press[2] = 4'h0;
        wait_mode(M_REL, 50, "s4_rel");
        kv0 = kv_cnt;
        press[2] = 4'b0010;
        wait_mode(M_HELD, 20, "s4_reheld");
        chk("s4_reheld_flag", key_held, 1);
        chk("s4_reheld_cols", columns, 4'b1011);
        cyc(20);
        chk("s4_no_second_kv", kv_cnt - kv0, 0);
        press[2] = 4'h0;
        wait_release(100, "s4_release");

        // 5: two keys in column 0
        press[0] = 4'b0011;
        cyc(16);
        kv0 = kv_cnt; mk0 = mk_cnt;
        cyc(64);
        chk("s5_mk_per_visit", mk_cnt - mk0, 4);
        chk("s5_no_kv", kv_cnt - kv0, 0);
        press[0] = 4'h0;
        cyc(8);

        // 6: reset during debounce
        press[2] = 4'b0010;
        begin
            int i = 0;
            while (!(m_mode == M_DEB && m_n == 2) && i < 100) begin cyc(1); i++; end
            if (!(m_mode == M_DEB && m_n == 2)) tmo("s6_deb2");
        end
        kv0 = kv_cnt;
        reset_n = 1'b0;
        #1;
        chk("s6_reset_outs", {columns, counter, keyboard, key_valid, key_held, multi_key},
            {4'b1110, 2'b00, 4'b1111, 3'b000});
        cyc(3);
        reset_n = 1'b1;
        chk("s6_no_kv_in_reset", kv_cnt - kv0, 0);
        wait_kv(100, "s6_kv", lat);
        chk("s6_fresh_latency", lat, 20);
        press[2] = 4'h0;
        wait_release(100, "s6_release");

        // randomized traffic, including bounces, multi-key rows and stray resets
        for (int it = 0; it < 150; it++) begin
            int c, r, hold;
            logic [3:0] mask;
            c = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            mask = (r < 7) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
            press[c] = mask;
            if ($urandom_range(0, 7) == 0) press[(c + 1) % 4] = 4'b0001 << $urandom_range(0, 3);
            hold = $urandom_range(1, 40);
            for (int k = 0; k < hold; k++) begin
                cyc(1);
                if ($urandom_range(0, 7) == 0) press[c] = press[c] ^ mask;
                if ($urandom_range(0, 199) == 0) begin
                    reset_n = 1'b0;
                    cyc($urandom_range(1, 3));
                    reset_n = 1'b1;
                end
            end
            for (int j = 0; j < 4; j++) press[j] = 4'h0;
            cyc($urandom_range(1, 40));
        end

        cyc(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 keypad columns with an active-low one-hot scan, synchronises the raw row lines, and debounces key presses and releases.
- Presents a stable {counter, keyboard} pair to the downstream encoder stage, which maps it to a hex digit one clock later.
- Emits a single-cycle key_valid per debounced press and flags illegal multi-key rows.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; legal range is 4 or more.
- DEBOUNCE_CNT, 8, consecutive matching samples (ticks) required to accept a press or a release; legal range is 1 to 255.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rows  input  4  raw keypad rows, active-low, asynchronous to clock
- columns  output  4  column drive, active-low one-hot
- counter  output  2  column index of the accepted key, to encoder
- keyboard  output  4  row code of the accepted key (one zero bit), to encoder
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high while an accepted key is still down (states HELD, RELEASE)
- multi_key  output  1  one-cycle pulse when a sample shows two or more rows low

Behaviour:
- Reset values (asynchronous):
  - columns=1110; counter=00; keyboard=1111; key_valid=0; key_held=0; multi_key=0.
  - Row synchroniser=1111; prescaler=0; stable count=0; scan index=0; state=SCAN.
- Synchroniser:
  - rows pass through two flops; all decisions use the second stage.
  - Latency is 2 cycles, so SCAN_DIV must be 4 or more to let rows settle after a column change.
- Tick:
  - The prescaler counts 0..SCAN_DIV-1 and wraps; tick=1 when prescaler==SCAN_DIV-1.
  - All sampling and state transitions happen only on tick.
- Column drive: columns = ~(1 << scan_index) at all times. scan_index advances (3 wraps to 0) only on a tick in SCAN with no detection, or on leaving DEBOUNCE/RELEASE back to SCAN.
- Definitions used below: S is the synchronised row sample at tick. "Single" means S has exactly one zero bit. "Idle" means S==1111.
- States:
  - SCAN:
    - Idle: advance the column.
    - Single: capture cap_row=S, cap_col=scan_index, set count=1, go to DEBOUNCE; the column is not advanced.
    - Two or more zeros: pulse multi_key, advance the column, stay in SCAN.
  - DEBOUNCE:
    - S==cap_row: count++. When count reaches DEBOUNCE_CNT, load keyboard=cap_row and counter=cap_col, pulse key_valid in that same cycle, go to HELD.
    - S!=cap_row: go to SCAN and advance the column; no output changes.
    - If DEBOUNCE_CNT==1, the accept happens on the detecting tick, SCAN going straight to HELD.
  - HELD:
    - The column stays fixed.
    - Idle: count=1, go to RELEASE.
    - Otherwise stay; any row pattern is ignored.
  - RELEASE:
    - Idle: count++. At DEBOUNCE_CNT, go to SCAN and advance the column.
    - Not idle: go to HELD; no new key_valid.
- Outputs:
  - keyboard and counter change only on the accept cycle and hold their last value otherwise, including after release.
  - key_valid and multi_key are never high in consecutive cycles.
  - key_held goes to 1 on the accept cycle and clears on the cycle the FSM enters SCAN.
- Reset mid-operation returns every register to its reset value immediately. No key_valid is issued for a press that was being debounced.
- Only one key is tracked at a time. Keys in other columns are invisible while in DEBOUNCE, HELD or RELEASE.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3. The bench models rows combinationally from columns.
1. Reset, no keys → all outputs at reset values. columns steps 1110→1101→1011→0111→1110, one step every 4 cycles. key_valid and multi_key stay 0 for 100 cycles.
2. Key at column 2 / row 1 (rows=1101 whenever columns==1011), held 200 cycles → exactly one key_valid, 8 cycles after the detecting tick. Then counter=10, keyboard=1101, key_held=1, columns frozen at 1011; downstream encoder outputs 7.
3. Release the key from scenario 2 → key_held drops 12 cycles after rows go idle. Scanning resumes at columns=0111; keyboard/counter keep 1101/10.
4. Bounce: the key is present for 1 tick only, then idle → no key_valid. FSM returns to SCAN and the next column (0111) is driven. A release-side glitch of 1 tick returns RELEASE→HELD with no second key_valid.
5. Two keys in column 0 (rows=1100 when columns==1110) → one multi_key pulse per visit to column 0; no key_valid; scanning continues.
6. Assert reset_n=0 in DEBOUNCE after 2 matching ticks, release after 3 cycles with the key still held → outputs at reset values and no key_valid during reset. After reset, the press is detected afresh and needs a full 3 matching ticks.
